// File: rtl/ysyx_23060124_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and small op-classification helpers.
package ysyx_23060124_mdu_pkg;

  localparam int MD_OP_WIDTH = 3;

  typedef enum logic [MD_OP_WIDTH-1:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_is_rem(input md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  // rs1 is interpreted as two's complement for these ops
  function automatic logic md_src1_signed(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // rs2 is interpreted as two's complement for these ops (MULHSU excluded)
  function automatic logic md_src2_signed(input md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/ysyx_23060124_mdu_signfix.sv
// Two-lane conditional negation. Used on entry to turn signed operands into
// magnitudes and on exit to re-apply the result sign; each lane has its own
// width so the exit side can negate the full double-width product.
module ysyx_23060124_mdu_signfix #(
  parameter int WA = 32,
  parameter int WB = 32
) (
  input  logic [WA-1:0] i_a,
  input  logic          i_a_neg,
  input  logic [WB-1:0] i_b,
  input  logic          i_b_neg,
  output logic [WA-1:0] o_a,
  output logic [WB-1:0] o_b
);

  assign o_a = i_a_neg ? (~i_a + WA'(1)) : i_a;
  assign o_b = i_b_neg ? (~i_b + WB'(1)) : i_b;

endmodule

// File: rtl/ysyx_23060124_mdu.sv
// Iterative RV32M/RV64M multiply-divide unit: one bit per cycle, operands in
// and result out over valid/ready, flushable at any time.
//
// state | meaning
// IDLE  | ready for a request; fast-path results skip straight to DONE
// CALC  | iterating, counter runs XLEN down to 1
// DONE  | result held on o_res with o_valid until i_ready
module ysyx_23060124_mdu
  import ysyx_23060124_mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [MD_OP_WIDTH-1:0] i_op,
  input  logic [XLEN-1:0]        i_src1,
  input  logic [XLEN-1:0]        i_src2,
  input  logic                   i_flush,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [XLEN-1:0]        o_res,
  output logic                   o_busy
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  md_op_e            op_q, req_op;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_step;
  logic [XLEN-1:0]   opd_q;
  logic              sign_q;
  logic [XLEN-1:0]   res_q;

  logic              accept, last_iter;
  logic              s1_neg, s2_neg, req_sign;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_by_zero, sgn_ovf, fast;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
  logic [XLEN-1:0]   div_pick;
  logic [2*XLEN-1:0] fix_prod;
  logic [XLEN-1:0]   fix_div;
  logic [XLEN-1:0]   calc_res;

  assign req_op    = md_op_e'(i_op);
  assign accept    = i_valid && !i_flush && (state_q == ST_IDLE);
  assign last_iter = (state_q == ST_CALC) && (cnt_q == CNT_W'(1));

  // Entry: magnitudes of the operands and the sign the result must carry
  assign s1_neg   = md_src1_signed(req_op) && i_src1[XLEN-1];
  assign s2_neg   = md_src2_signed(req_op) && i_src2[XLEN-1];
  assign req_sign = (req_op == MD_REM) ? s1_neg : (s1_neg ^ s2_neg);

  ysyx_23060124_mdu_signfix #(.WA(XLEN), .WB(XLEN)) u_entry_fix (
    .i_a     (i_src1),
    .i_a_neg (s1_neg),
    .i_b     (i_src2),
    .i_b_neg (s2_neg),
    .o_a     (mag1),
    .o_b     (mag2)
  );

  // Special cases that resolve without iterating
  assign div_by_zero = md_is_div(req_op) && (i_src2 == '0);
  assign sgn_ovf     = (req_op == MD_DIV || req_op == MD_REM) &&
                       (i_src1 == XMIN) && (i_src2 == '1);
  assign fast        = div_by_zero || sgn_ovf;

  // Fast-path result: /0 gives all ones or the dividend, MIN/-1 gives MIN or 0
  always_comb begin
    fast_res = '0;
    if (div_by_zero)
      fast_res = md_is_rem(req_op) ? i_src1 : '1;
    else if (sgn_ovf)
      fast_res = md_is_rem(req_op) ? '0 : i_src1;
  end

  // One iteration step on the shared accumulator: shift-add or restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opd_q : '0)};
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    rem_diff  = rem_shift - {1'b0, opd_q};
    if (md_is_div(op_q)) begin
      if (rem_diff[XLEN])
        acc_step = {acc_q[2*XLEN-2:0], 1'b0};
      else
        acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Divide leaves the remainder in the high half and the quotient in the low half
  assign div_pick = md_is_rem(op_q) ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];

  ysyx_23060124_mdu_signfix #(.WA(2*XLEN), .WB(XLEN)) u_exit_fix (
    .i_a     (acc_step),
    .i_a_neg (sign_q),
    .i_b     (div_pick),
    .i_b_neg (sign_q),
    .o_a     (fix_prod),
    .o_b     (fix_div)
  );

  // Final result select from the sign-corrected product or quotient/remainder
  always_comb begin
    if (md_is_div(op_q))
      calc_res = fix_div;
    else if (op_q == MD_MUL)
      calc_res = fix_prod[XLEN-1:0];
    else
      calc_res = fix_prod[2*XLEN-1:XLEN];
  end

  // FSM state register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // FSM next state and state-decoded handshake outputs
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (accept)
          state_d = fast ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        o_busy = 1'b1;
        if (last_iter)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        if (i_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_flush)
      state_d = ST_IDLE;
  end

  // Datapath registers: operand capture, iteration and result write
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q   <= MD_MUL;
      sign_q <= 1'b0;
      opd_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= req_op;
            sign_q <= req_sign;
            opd_q  <= mag2;
            acc_q  <= {{XLEN{1'b0}}, mag1};
            cnt_q  <= fast ? '0 : CNT_W'(XLEN);
            if (fast)
              res_q <= fast_res;
          end
        end
        ST_CALC: begin
          if (i_flush) begin
            cnt_q <= '0;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_iter)
              res_q <= calc_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_res = res_q;

endmodule

// File: tb/tb_ysyx_23060124_mdu.sv
// Bench for the multiply-divide unit: directed vectors with literal answers,
// then randomized traffic with stalls and flushes against an arithmetic model.
module tb_ysyx_23060124_mdu;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_op = 3'd0;
  logic [31:0] i_src1 = '0;
  logic [31:0] i_src2 = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_res;
  logic        o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  bit   idle_m;
  bit   exp_valid;

  ysyx_23060124_mdu #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_src1  (i_src1),
    .i_src2  (i_src2),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics computed with 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = '0;
    case (op)
      3'd0: p = ua * ub;
      3'd1: p = sa * sb;
      3'd2: p = sa * longint'(ub);
      3'd3: p = ua * ub;
      3'd4: begin
        if (b == 0) p = '1;
        else if (a == MIN && b == 32'hFFFF_FFFF) p = {32'h0, MIN};
        else p = sa / sb;
      end
      3'd5: begin
        if (b == 0) p = '1;
        else p = ua / ub;
      end
      3'd6: begin
        if (b == 0) p = ua;
        else if (a == MIN && b == 32'hFFFF_FFFF) p = '0;
        else p = sa % sb;
      end
      default: begin
        if (b == 0) p = ua;
        else p = ua % ub;
      end
    endcase
    if (op == 3'd1 || op == 3'd2 || op == 3'd3)
      return p[63:32];
    return p[31:0];
  endfunction

  function automatic bit ref_fast(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == MIN && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return 32'($urandom_range(0, 15));
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Compare process: the model knows what is in flight and when it is due
  always @(negedge clk) begin
    if (!i_rst_n) begin
      q.delete();
    end else if (chk_en) begin
      idle_m    = (q.size() == 0);
      exp_valid = 1'b0;
      if (!idle_m)
        exp_valid = (cyc - q[0].acc) >= q[0].lat;
      check("o_valid", o_valid, exp_valid);
      check("o_busy", o_busy, !idle_m);
      check("o_ready", o_ready, idle_m);
      if (exp_valid)
        check("o_res", o_res, q[0].res);
      if (!idle_m && (i_flush || (exp_valid && i_ready)))
        void'(q.pop_front());
      if (idle_m && i_valid && !i_flush) begin
        e_m.res = ref_md(i_op, i_src1, i_src2);
        e_m.acc = cyc;
        e_m.lat = ref_fast(i_op, i_src1, i_src2) ? 1 : XLEN + 1;
        q.push_back(e_m);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_op    = op;
    i_src1  = a;
    i_src2  = b;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ready && n < 100);
    if (!o_ready) check("send_timeout", o_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // Wait for the result, optionally stall (and poke a request), then handshake
  task automatic collect(input int stall, input bit poke, input bit early,
                         output logic [31:0] res, output int lat, output int rdy_hi);
    int n = 0;
    rdy_hi = 0;
    if (early) i_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (o_ready) rdy_hi++;
    end while (!o_valid && n < 100);
    if (!o_valid) check("valid_timeout", o_valid, 1);
    lat = n;
    if (early) begin
      res = o_res;
      @(posedge clk); #1;
      i_ready = 1'b0;
    end else begin
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        if (poke) begin
          i_valid = 1'b1;
          i_op    = 3'd5;
          i_src1  = $urandom;
          i_src2  = 32'd3;
        end
        @(negedge clk);
        if (o_ready) rdy_hi++;
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      res = o_res;
      @(posedge clk); #1;
      i_ready = 1'b0;
    end
  endtask

  task automatic dir(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] r;
    int lat, rh;
    send(op, a, b);
    collect(0, 1'b0, 1'b0, r, lat, rh);
    check({name, "_res"}, r, exp);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_rdy_low"}, rh, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, a, b;
    logic [2:0]  op;
    int lat, rh, mode, nv;

    #12;
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_res", o_res, 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    chk_en  = 1'b1;

    dir("mul",     3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    dir("mulh",    3'd1, MIN,          MIN,           32'h4000_0000, 33);
    dir("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    dir("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    dir("div",     3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
    dir("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
    dir("divu",    3'd5, 32'd100,      32'd7,         32'd14,        33);
    dir("remu",    3'd7, 32'd100,      32'd7,         32'd2,         33);
    dir("divu_z",  3'd5, 32'd5,        32'd0,         32'hFFFF_FFFF, 1);
    dir("rem_z",   3'd6, 32'd5,        32'd0,         32'd5,         1);
    dir("div_ovf", 3'd4, MIN,          32'hFFFF_FFFF, MIN,           1);
    dir("rem_ovf", 3'd6, MIN,          32'hFFFF_FFFF, 32'd0,         1);

    // Long result stall with a competing request on the input
    send(3'd5, 32'd100, 32'd7);
    collect(10, 1'b1, 1'b0, r, lat, rh);
    check("stall_res", r, 32'd14);
    check("stall_lat", lat, 33);
    check("stall_rdy_low", rh, 0);

    // Request together with flush in IDLE is ignored
    @(posedge clk); #1;
    i_valid = 1'b1; i_flush = 1'b1; i_op = 3'd0; i_src1 = 32'd3; i_src2 = 32'd3;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    @(negedge clk);
    check("flush_req_busy", o_busy, 0);

    // Flush in the fifth CALC cycle
    send(3'd0, 32'd3, 32'd5);
    repeat (4) begin
      @(posedge clk); #1;
    end
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    @(negedge clk);
    check("flush_ready", o_ready, 1);
    check("flush_busy", o_busy, 0);
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid) nv++;
    end
    check("flush_no_valid", nv, 0);
    dir("after_flush", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

    // Asynchronous reset in the middle of CALC
    send(3'd4, 32'h0123_4567, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_ready", o_ready, 1);
    check("arst_busy", o_busy, 0);
    check("arst_res", o_res, 0);
    @(posedge clk);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    dir("after_rst", 3'd7, 32'd100, 32'd7, 32'd2, 33);

    // Randomized traffic with stalls, early ready and flushes
    for (int it = 0; it < 150; it++) begin
      op   = 3'($urandom_range(0, 7));
      a    = pick();
      b    = pick();
      mode = $urandom_range(0, 7);
      send(op, a, b);
      if (mode == 0) begin
        repeat ($urandom_range(0, 36)) begin
          @(posedge clk); #1;
        end
        i_flush = 1'b1;
        i_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        i_flush = 1'b0;
        i_ready = 1'b0;
      end else begin
        collect($urandom_range(0, 3), 1'b0, mode == 1, r, lat, rh);
      end
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
